pc_unit: RTL and testbench

Parametrised program counter for the single-cycle RISC-V core, generalising the fixed 32-bit PC.
- Holds the fetch address and advances it by a configurable step each cycle.
- Accepts branch/jump redirects, stall and halt requests, and an optional misaligned-target trap.
- Counts advanced instructions.
- Sits between the branch-resolution logic and the instruction-memory address port.

---
 rtl/pc_unit.sv | 139 +++++++++++++
 tb/tb_pc_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with RUN/HALT/TRAP control, redirects and a saturating advance counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect targets trap instead of being truncated).
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             finish_flag,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             resume,
  output logic [XLEN-1:0]  pc_reg,
  output logic [XLEN-1:0]  pc_next,
  output logic             pc_valid,
  output logic             halted,
  output logic             trap,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);

  state_t           r_state;
  state_t           w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_advance;
  logic             w_misaligned;
  logic [XLEN-1:0]  w_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0]  r_trap_pc;
  logic [XLEN-1:0]  w_trap_pc_next;

  assign w_misaligned = |(redirect_target & ALIGN_MASK);
  assign w_target     = redirect_target;
`else
  // Without the trap, a misaligned target is silently aligned down and accepted.
  assign w_misaligned = 1'b0;
  assign w_target     = redirect_target & ~ALIGN_MASK;
`endif

  // Next-state / next-PC. Priority in RUN: halt, trap, redirect, stall, increment.
  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = r_pc;
    w_advance    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    w_trap_pc_next = r_trap_pc;
`endif
    case (r_state)
      ST_RUN: begin
        if (finish_flag) begin
          w_state_next = ST_HALT;
        end else if (redirect_valid && w_misaligned) begin
          w_state_next = ST_TRAP;
`ifdef PC_MISALIGN_TRAP_EN
          w_trap_pc_next = redirect_target;
`endif
        end else if (redirect_valid) begin
          w_pc_sel  = w_target;
          w_advance = 1'b1;
        end else if (!stall) begin
          w_pc_sel  = r_pc + STEP_X;
          w_advance = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume && !finish_flag) begin
          w_state_next = ST_RUN;
        end
      end
      ST_TRAP: begin
        if (resume) begin
          w_state_next = ST_RUN;
          w_pc_sel     = RESET_VECTOR;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_VECTOR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_sel;
      if (w_advance && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_trap_pc <= '0;
    end else begin
      r_trap_pc <= w_trap_pc_next;
    end
  end

  assign trap    = (r_state == ST_TRAP);
  assign trap_pc = r_trap_pc;
`else
  assign trap    = 1'b0;
  assign trap_pc = '0;
`endif

  // pc_valid is a valid-only strobe toward instruction memory: the fetch
  // address on pc_reg is meaningful in any cycle where pc_valid=1; there is
  // no ready back-pressure, the consumer stalls the PC through the stall input.
  assign pc_valid    = (r_state == ST_RUN) && !stall;
  assign pc_reg      = r_pc;
  assign pc_next     = reset ? w_pc_sel : RESET_VECTOR;
  assign halted      = (r_state == ST_HALT);
  assign instr_count = r_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: reset, free run, redirect, stall, halt, misalign, wrap and counter saturation.
module tb_pc_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             finish_flag = 1'b0;
  logic             stall = 1'b0;
  logic             redirect_valid = 1'b0;
  logic [XLEN-1:0]  redirect_target = '0;
  logic             resume = 1'b0;

  logic [XLEN-1:0]  pc_reg, pc_next, trap_pc;
  logic             pc_valid, halted, trap;
  logic [CNT_W-1:0] instr_count;
  logic [1:0]       dbg_state;

  logic [XLEN-1:0]  s_pc_reg, s_pc_next, s_trap_pc;
  logic             s_pc_valid, s_halted, s_trap;
  logic [2:0]       s_instr_count;
  logic [1:0]       s_dbg_state;

  logic [XLEN-1:0]  exp_q[$];
  logic [XLEN-1:0]  exp;
  int               n_vec = 0;
  int               n_err = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .finish_flag(finish_flag), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .resume(resume),
    .pc_reg(pc_reg), .pc_next(pc_next), .pc_valid(pc_valid), .halted(halted),
    .trap(trap), .trap_pc(trap_pc), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  pc_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .finish_flag(finish_flag), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .resume(resume),
    .pc_reg(s_pc_reg), .pc_next(s_pc_next), .pc_valid(s_pc_valid), .halted(s_halted),
    .trap(s_trap), .trap_pc(s_trap_pc), .instr_count(s_instr_count), .dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; finish_flag = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; resume = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_vec++;
    if (pc_next !== 32'h0) begin n_err++; $display("FAIL reset_pc_next got %h want %h", pc_next, 32'h0); end
    tick();
    n_vec++;
    if (pc_reg !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc_reg, 32'h0); end
    n_vec++;
    if ({halted, trap} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {halted, trap}); end
    n_vec++;
    if (trap_pc !== 32'h0) begin n_err++; $display("FAIL reset_trap_pc got %h want 0", trap_pc); end
    n_vec++;
    if (instr_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", instr_count); end
    n_vec++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'(4 * i));
      n_vec++;
      if (pc_valid !== 1'b1) begin n_err++; $display("FAIL free_valid got %b want 1", pc_valid); end
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if (pc_reg !== exp) begin n_err++; $display("FAIL free_pc got %h want %h", pc_reg, exp); end
    end
    n_vec++;
    if (instr_count !== 32'd4) begin n_err++; $display("FAIL free_count got %0d want 4", instr_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick();
    n_vec++;
    if (pc_reg !== 32'h8) begin n_err++; $display("FAIL redir_start got %h want 8", pc_reg); end
    redirect_valid = 1'b1; redirect_target = 32'h100;
    exp_q.push_back(32'h100);
    #1;
    n_vec++;
    if (pc_next !== 32'h100) begin n_err++; $display("FAIL redir_pc_next got %h want 100", pc_next); end
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if (pc_reg !== exp) begin n_err++; $display("FAIL redir_pc got %h want %h", pc_reg, exp); end
    redirect_valid = 1'b0;
    exp_q.push_back(32'h104);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if (pc_reg !== exp) begin n_err++; $display("FAIL redir_after got %h want %h", pc_reg, exp); end
    n_vec++;
    if (instr_count !== 32'd4) begin n_err++; $display("FAIL redir_count got %0d want 4", instr_count); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h10);
      #1;
      n_vec++;
      if (pc_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid got %b want 0", pc_valid); end
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if (pc_reg !== exp) begin n_err++; $display("FAIL stall_pc got %h want %h", pc_reg, exp); end
      n_vec++;
      if (instr_count !== 32'd4) begin n_err++; $display("FAIL stall_count got %0d want 4", instr_count); end
    end
    stall = 1'b0;
    tick();
    n_vec++;
    if (pc_reg !== 32'h14) begin n_err++; $display("FAIL stall_release got %h want 14", pc_reg); end
    n_vec++;
    if (instr_count !== 32'd5) begin n_err++; $display("FAIL stall_rel_count got %0d want 5", instr_count); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (8) tick();
    finish_flag = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    #1;
    n_vec++;
    if (pc_next !== 32'h20) begin n_err++; $display("FAIL halt_pc_next got %h want 20", pc_next); end
    tick();
    n_vec++;
    if ({halted, pc_reg} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL halt_enter got %b/%h want 1/20", halted, pc_reg); end
    finish_flag = 1'b0;
    tick();
    n_vec++;
    if ({halted, pc_reg} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL halt_hold got %b/%h want 1/20", halted, pc_reg); end
    n_vec++;
    if (instr_count !== 32'd8) begin n_err++; $display("FAIL halt_count got %0d want 8", instr_count); end
    n_vec++;
    if (dbg_state !== 2'd1) begin n_err++; $display("FAIL halt_state got %0d want 1", dbg_state); end
    resume = 1'b1; finish_flag = 1'b1;
    tick();
    n_vec++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL halt_both got %b want 1", halted); end
    finish_flag = 1'b0;
    tick();
    n_vec++;
    if ({halted, pc_reg} !== {1'b0, 32'h20}) begin n_err++; $display("FAIL halt_resume got %b/%h want 0/20", halted, pc_reg); end
    resume = 1'b0; redirect_valid = 1'b0;
    tick();
    n_vec++;
    if (pc_reg !== 32'h24) begin n_err++; $display("FAIL halt_next got %h want 24", pc_reg); end
    n_vec++;
    if (instr_count !== 32'd9) begin n_err++; $display("FAIL halt_next_count got %0d want 9", instr_count); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    n_vec++;
    if ({trap, pc_reg} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL mis_trap got %b/%h want 1/8", trap, pc_reg); end
    n_vec++;
    if (trap_pc !== 32'h102) begin n_err++; $display("FAIL mis_trap_pc got %h want 102", trap_pc); end
    finish_flag = 1'b1;
    tick();
    n_vec++;
    if ({trap, halted, pc_reg} !== {2'b10, 32'h8}) begin n_err++; $display("FAIL mis_hold got %b%b/%h want 10/8", trap, halted, pc_reg); end
    finish_flag = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    n_vec++;
    if ({trap, pc_reg} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL mis_resume got %b/%h want 0/0", trap, pc_reg); end
    n_vec++;
    if (trap_pc !== 32'h102) begin n_err++; $display("FAIL mis_keep got %h want 102", trap_pc); end
    n_vec++;
    if (instr_count !== 32'd2) begin n_err++; $display("FAIL mis_count got %0d want 2", instr_count); end
`else
    n_vec++;
    if ({trap, pc_reg} !== {1'b0, 32'h100}) begin n_err++; $display("FAIL mis_align got %b/%h want 0/100", trap, pc_reg); end
    n_vec++;
    if (trap_pc !== 32'h0) begin n_err++; $display("FAIL mis_trap_pc got %h want 0", trap_pc); end
    n_vec++;
    if (instr_count !== 32'd3) begin n_err++; $display("FAIL mis_count got %0d want 3", instr_count); end
`endif
  endtask

  task automatic test_wrap_reset();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_vec++;
    if (pc_reg !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc_reg); end
    n_vec++;
    if (instr_count !== 32'd2) begin n_err++; $display("FAIL wrap_count got %0d want 2", instr_count); end
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0; finish_flag = 1'b1;
    tick();
    n_vec++;
    if ({halted, pc_reg} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_halt got %b/%h want 1/fffffffc", halted, pc_reg); end
    reset = 1'b0;
    #1;
    n_vec++;
    if (pc_next !== 32'h0) begin n_err++; $display("FAIL rst_halt_pc_next got %h want 0", pc_next); end
    tick();
    n_vec++;
    if ({halted, trap, pc_reg, instr_count} !== {2'b00, 32'h0, 32'd0}) begin
      n_err++; $display("FAIL rst_halt got %b%b/%h/%0d want 00/0/0", halted, trap, pc_reg, instr_count);
    end
    reset = 1'b1; finish_flag = 1'b0;
    tick();
    n_vec++;
    if (pc_reg !== 32'h4) begin n_err++; $display("FAIL rst_halt_run got %h want 4", pc_reg); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back((i > 7) ? 32'd7 : 32'(i));
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if ({29'd0, s_instr_count} !== exp) begin n_err++; $display("FAIL sat_count got %0d want %0d", s_instr_count, exp); end
    end
    n_vec++;
    if (s_pc_reg !== 32'd40) begin n_err++; $display("FAIL sat_pc got %h want 28", s_pc_reg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_halt();
    test_misalign();
    test_wrap_reset();
    test_saturate();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
